// File: rtl/problem_scheduler_pkg.sv
// Shared types and default widths for the column problem scheduler.
// Optional arithmetic overflow detection: PROBLEM_SCHEDULER_OVF_CHECK_EN.
package problem_scheduler_pkg;

   localparam int DEF_ARG_ROWS       = 3;
   localparam int DEF_ARG_ROW_WIDTH  = 2;
   localparam int DEF_ARG_COL_WIDTH  = 10;
   localparam int DEF_ARG_DATA_WIDTH = 16;
   localparam int DEF_RESULT_WIDTH   = 48;
   localparam int DEF_TOTAL_WIDTH    = 64;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FETCH   = 2'd1,
      COMBINE = 2'd2,
      EMIT    = 2'd3
   } sched_state_t;

   typedef enum logic {
      OP_ADD  = 1'b0,
      OP_MULT = 1'b1
   } op_t;

   typedef struct packed {
      logic [DEF_ARG_COL_WIDTH-1:0] col;
      op_t                          op;
   } op_entry_t;

endpackage

// File: rtl/problem_scheduler_op_queue.sv
// Single-clock first-word-fall-through FIFO of pending column operators.
// Optional arithmetic overflow detection: PROBLEM_SCHEDULER_OVF_CHECK_EN.
module op_queue
   import problem_scheduler_pkg::*;
#(
   parameter int  AW      = DEF_ARG_COL_WIDTH,
   parameter type entry_t = op_entry_t
)(
   input  logic   clk,
   input  logic   rst,
   input  logic   push_i,
   input  entry_t push_data_i,
   input  logic   pop_i,
   output entry_t head_o,
   output logic   empty_o,
   output logic   full_o,
   output logic   drop_o
);

   localparam int DEPTH = 2**AW;

   entry_t        mem_q [DEPTH];
   logic [AW-1:0] wr_q, wr_d;
   logic [AW-1:0] rd_q, rd_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          do_pop;
   logic          do_push;

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == (AW+1)'(DEPTH));
   assign head_o  = mem_q[rd_q];

   // Pointer and occupancy bookkeeping; a pop frees the slot a full push needs.
   always_comb begin
      do_pop  = pop_i & ~empty_o;
      do_push = push_i & (~full_o | do_pop);
      drop_o  = push_i & ~do_push;
      wr_d    = do_push ? wr_q + AW'(1) : wr_q;
      rd_d    = do_pop ? rd_q + AW'(1) : rd_q;
      cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
   end

   // Entry storage, never reset.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= push_data_i;
   end

   // Pointer registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/problem_scheduler.sv
// Stores decoded arguments, queues operators, evaluates one column at a time.
// Optional arithmetic overflow detection: PROBLEM_SCHEDULER_OVF_CHECK_EN.
module problem_scheduler
   import problem_scheduler_pkg::*;
#(
   parameter int ARG_ROWS       = DEF_ARG_ROWS,
   parameter int ARG_ROW_WIDTH  = DEF_ARG_ROW_WIDTH,
   parameter int ARG_COL_WIDTH  = DEF_ARG_COL_WIDTH,
   parameter int ARG_DATA_WIDTH = DEF_ARG_DATA_WIDTH,
   parameter int RESULT_WIDTH   = DEF_RESULT_WIDTH,
   parameter int TOTAL_WIDTH    = DEF_TOTAL_WIDTH
)(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      arg_valid,
   input  logic [ARG_ROW_WIDTH-1:0]  arg_row,
   input  logic [ARG_COL_WIDTH-1:0]  arg_col,
   input  logic [ARG_DATA_WIDTH-1:0] arg_data,
   input  logic                      operand_valid,
   input  logic                      operand_mult_add,
   input  logic                      end_of_input,
   output logic                      result_valid,
   output logic [ARG_COL_WIDTH-1:0]  result_col,
   output logic [RESULT_WIDTH-1:0]   result_data,
   output logic [TOTAL_WIDTH-1:0]    total_data,
   output logic                      done,
   output logic                      overflow
);

   localparam int RW = RESULT_WIDTH;
   localparam int DW = ARG_DATA_WIDTH;
   localparam int TW = TOTAL_WIDTH;
   localparam int AW = ARG_COL_WIDTH + ARG_ROW_WIDTH;
   localparam logic [ARG_ROW_WIDTH-1:0] LAST_ROW =
      ARG_ROW_WIDTH'(ARG_ROWS - 1);

   typedef struct packed {
      logic [ARG_COL_WIDTH-1:0] col;
      op_t                      op;
   } entry_t;

   logic [DW-1:0]            arg_mem [2**AW];
   logic [DW-1:0]            rd_data_q;

   sched_state_t             state_q, state_d;
   logic [ARG_COL_WIDTH-1:0] col_q, col_d;
   op_t                      op_q, op_d;
   logic [ARG_ROW_WIDTH-1:0] row_q, row_d;
   logic [RW-1:0]            acc_q, acc_d;
   logic [TW-1:0]            total_q, total_d;
   logic [ARG_COL_WIDTH-1:0] op_cnt_q, op_cnt_d;
   logic                     end_seen_q, end_seen_d;
   logic                     done_q, done_d;
   logic                     ovf_q, ovf_d;

   entry_t                   push_ent;
   entry_t                   head;
   logic                     q_pop;
   logic                     q_empty;
   logic                     q_full;
   logic                     q_drop;
   logic [RW-1:0]            comb_val;
   logic [TW-1:0]            tot_val;
   logic                     arith_ovf;

`ifdef PROBLEM_SCHEDULER_OVF_CHECK_EN
   logic [RW+DW-1:0]         prod_full;
   logic [RW:0]              sum_full;
   logic [TW:0]              tot_full;
`endif

   // Argument store: row-major per column, synchronous read while fetching.
   always_ff @(posedge clk) begin
      if (arg_valid && arg_row <= LAST_ROW)
         arg_mem[{arg_col, arg_row}] <= arg_data;
      if (state_q == FETCH)
         rd_data_q <= arg_mem[{col_q, row_q}];
   end

   assign push_ent = '{col: op_cnt_q, op: op_t'(operand_mult_add)};
   assign q_pop    = (state_q == IDLE) & ~q_empty;

   op_queue #(
      .AW      (ARG_COL_WIDTH),
      .entry_t (entry_t)
   ) u_op_queue (
      .clk         (clk),
      .rst         (rst),
      .push_i      (operand_valid),
      .push_data_i (push_ent),
      .pop_i       (q_pop),
      .head_o      (head),
      .empty_o     (q_empty),
      .full_o      (q_full),
      .drop_o      (q_drop)
   );

   // Shared combine datapath and total adder, with optional width checks.
   always_comb begin
`ifdef PROBLEM_SCHEDULER_OVF_CHECK_EN
      prod_full = {{DW{1'b0}}, acc_q} * {{RW{1'b0}}, rd_data_q};
      sum_full  = {1'b0, acc_q} + {{(RW+1-DW){1'b0}}, rd_data_q};
      tot_full  = {1'b0, total_q} + {{(TW+1-RW){1'b0}}, acc_q};
      comb_val  = (op_q == OP_MULT) ? prod_full[RW-1:0] : sum_full[RW-1:0];
      tot_val   = tot_full[TW-1:0];
      arith_ovf = ((state_q == COMBINE) &
                   ((op_q == OP_MULT) ? |prod_full[RW+DW-1:RW]
                                      : sum_full[RW])) |
                  ((state_q == EMIT) & tot_full[TW]);
`else
      comb_val  = (op_q == OP_MULT) ? acc_q * RW'(rd_data_q)
                                    : acc_q + RW'(rd_data_q);
      tot_val   = total_q + TW'(acc_q);
      arith_ovf = 1'b0;
`endif
   end

   // Column sequencer plus done/overflow bookkeeping.
   always_comb begin
      state_d    = state_q;
      col_d      = col_q;
      op_d       = op_q;
      row_d      = row_q;
      acc_d      = acc_q;
      total_d    = total_q;
      op_cnt_d   = operand_valid ? op_cnt_q + ARG_COL_WIDTH'(1) : op_cnt_q;
      end_seen_d = end_seen_q | end_of_input;
      done_d     = done_q |
                   ((end_seen_q | end_of_input) & q_empty &
                    ~operand_valid & (state_q == IDLE));
      ovf_d      = ovf_q | q_drop | arith_ovf;
      unique case (state_q)
         IDLE: begin
            if (!q_empty) begin
               col_d   = head.col;
               op_d    = head.op;
               acc_d   = (head.op == OP_MULT) ? RW'(1) : '0;
               row_d   = '0;
               state_d = FETCH;
            end
         end
         FETCH: begin
            state_d = COMBINE;
         end
         COMBINE: begin
            acc_d   = comb_val;
            row_d   = row_q + ARG_ROW_WIDTH'(1);
            state_d = (row_q == LAST_ROW) ? EMIT : FETCH;
         end
         EMIT: begin
            total_d = tot_val;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers; argument storage is deliberately left untouched.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         col_q      <= '0;
         op_q       <= OP_ADD;
         row_q      <= '0;
         acc_q      <= '0;
         total_q    <= '0;
         op_cnt_q   <= '0;
         end_seen_q <= 1'b0;
         done_q     <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         col_q      <= col_d;
         op_q       <= op_d;
         row_q      <= row_d;
         acc_q      <= acc_d;
         total_q    <= total_d;
         op_cnt_q   <= op_cnt_d;
         end_seen_q <= end_seen_d;
         done_q     <= done_d;
         ovf_q      <= ovf_d;
      end
   end

   assign result_valid = (state_q == EMIT);
   assign result_col   = col_q;
   assign result_data  = acc_q;
   assign total_data   = total_q;
   assign done         = done_q;
   assign overflow     = ovf_q;

endmodule

// File: tb/tb_problem_scheduler.sv
// Randomised and directed bench for problem_scheduler with a column-level model.
// Overflow expectation of the narrow instance follows PROBLEM_SCHEDULER_OVF_CHECK_EN.
module tb_problem_scheduler;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        arg_valid, operand_valid, operand_mult_add, end_of_input;
   logic [1:0]  arg_row;
   logic [9:0]  arg_col;
   logic [15:0] arg_data;
   logic        result_valid, done, overflow;
   logic [9:0]  result_col;
   logic [47:0] result_data;
   logic [63:0] total_data;

   logic        arg_valid2, operand_valid2, operand_mult_add2, end_of_input2;
   logic [1:0]  arg_row2;
   logic [9:0]  arg_col2;
   logic [15:0] arg_data2;
   logic        result_valid2, done2, overflow2;
   logic [9:0]  result_col2;
   logic [15:0] result_data2;
   logic [63:0] total_data2;

   always #5 clk = ~clk;

   problem_scheduler dut (
      .clk(clk), .rst(rst),
      .arg_valid(arg_valid), .arg_row(arg_row), .arg_col(arg_col),
      .arg_data(arg_data), .operand_valid(operand_valid),
      .operand_mult_add(operand_mult_add), .end_of_input(end_of_input),
      .result_valid(result_valid), .result_col(result_col),
      .result_data(result_data), .total_data(total_data),
      .done(done), .overflow(overflow)
   );

   problem_scheduler #(.RESULT_WIDTH(16)) dut16 (
      .clk(clk), .rst(rst),
      .arg_valid(arg_valid2), .arg_row(arg_row2), .arg_col(arg_col2),
      .arg_data(arg_data2), .operand_valid(operand_valid2),
      .operand_mult_add(operand_mult_add2), .end_of_input(end_of_input2),
      .result_valid(result_valid2), .result_col(result_col2),
      .result_data(result_data2), .total_data(total_data2),
      .done(done2), .overflow(overflow2)
   );

   typedef struct {
      int              col;
      longint unsigned data;
   } exp_t;

   localparam longint unsigned MASK48 = (64'd1 << 48) - 64'd1;

   int              total = 0;
   int              bad   = 0;
   exp_t            expq[$];
   longint unsigned got[$];
   longint unsigned m_total;
   int              m_opcol;
   longint unsigned m_args [1024][3];

   int ex_args [3][4] = '{'{123, 328, 51, 64},
                          '{45, 64, 387, 23},
                          '{6, 98, 215, 314}};
   bit ex_ops [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
   longint unsigned ex_res [4] = '{33210, 490, 4243455, 401};

   task automatic chk(string nm, logic [63:0] act, logic [63:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", nm, act, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(int n);
      repeat (n) tick();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      expq.delete();
      got.delete();
      m_total = 0;
      m_opcol = 0;
      idle(2);
      rst = 1'b0;
   endtask

   task automatic send_arg(int c, int r, longint unsigned d);
      arg_valid = 1'b1;
      arg_col   = 10'(c);
      arg_row   = 2'(r);
      arg_data  = 16'(d);
      if (r < 3) m_args[c][r] = d & 64'hffff;
      tick();
      arg_valid = 1'b0;
   endtask

   // Model: a column's value is the fold of its three stored arguments.
   task automatic send_op(bit m);
      longint unsigned acc;
      exp_t e;
      operand_valid    = 1'b1;
      operand_mult_add = m;
      acc = m ? 64'd1 : 64'd0;
      for (int r = 0; r < 3; r++) begin
         acc = m ? acc * m_args[m_opcol][r] : acc + m_args[m_opcol][r];
         acc = acc & MASK48;
      end
      e.col  = m_opcol;
      e.data = acc;
      expq.push_back(e);
      m_opcol = (m_opcol + 1) % 1024;
      tick();
      operand_valid = 1'b0;
   endtask

   task automatic end_input();
      end_of_input = 1'b1;
      tick();
      end_of_input = 1'b0;
   endtask

   task automatic send_example(bit with_end);
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 3; r++)
            send_arg(c, r, longint'(ex_args[r][c]));
      for (int c = 0; c < 4; c++) send_op(ex_ops[c]);
      if (with_end) end_input();
   endtask

   task automatic wait_done(int budget, string nm);
      for (int i = 0; i < budget && !done; i++) tick();
      chk({nm, "_done"}, done, 1);
      chk({nm, "_pending"}, expq.size(), 0);
   endtask

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (!rst) begin
         chk("total_data", total_data, m_total);
         chk("overflow", overflow, 0);
         if (result_valid) begin
            got.push_back(result_data);
            if (expq.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_result col=%0d got=%0d want=none",
                        result_col, result_data);
            end else begin
               exp_t e;
               e = expq.pop_front();
               chk("result_col", result_col, e.col);
               chk("result_data", result_data, e.data);
               m_total = m_total + e.data;
            end
         end
      end
   end

   initial begin
      bit              seen;
      longint unsigned r16;
      arg_valid = 0; arg_row = 0; arg_col = 0; arg_data = 0;
      operand_valid = 0; operand_mult_add = 0; end_of_input = 0;
      arg_valid2 = 0; arg_row2 = 0; arg_col2 = 0; arg_data2 = 0;
      operand_valid2 = 0; operand_mult_add2 = 0; end_of_input2 = 0;

      do_reset();
      chk("rst_valid", result_valid, 0);
      chk("rst_col", result_col, 0);
      chk("rst_data", result_data, 0);
      chk("rst_total", total_data, 0);
      chk("rst_done", done, 0);
      chk("rst_ovf", overflow, 0);

      // Narrow result: 300*300*1 truncated to 16 bits.
      for (int r = 0; r < 3; r++) begin
         arg_valid2 = 1'b1;
         arg_col2   = 10'd0;
         arg_row2   = 2'(r);
         arg_data2  = (r == 2) ? 16'd1 : 16'd300;
         tick();
         arg_valid2 = 1'b0;
      end
      operand_valid2    = 1'b1;
      operand_mult_add2 = 1'b1;
      tick();
      operand_valid2 = 1'b0;
      seen = 0;
      r16  = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (result_valid2) begin
            seen = 1;
            r16  = result_data2;
         end
      end
      chk("w16_seen", seen, 1);
      chk("w16_result", r16, 24464);
      idle(2);
      chk("w16_total", total_data2, 24464);
`ifdef PROBLEM_SCHEDULER_OVF_CHECK_EN
      chk("w16_ovf", overflow2, 1);
`else
      chk("w16_ovf", overflow2, 0);
`endif

      // Worksheet example.
      send_example(1);
      wait_done(200, "ex");
      chk("ex_total", total_data, 4277556);
      chk("ex_count", got.size(), 4);
      for (int i = 0; i < 4 && i < got.size(); i++)
         chk("ex_result", got[i], ex_res[i]);

      // Eight add columns, operator every two cycles.
      do_reset();
      for (int c = 0; c < 8; c++)
         for (int r = 0; r < 3; r++) send_arg(c, r, r + 1);
      for (int c = 0; c < 8; c++) begin
         send_op(1'b0);
         idle(1);
      end
      end_input();
      wait_done(300, "add8");
      chk("add8_total", total_data, 48);
      chk("add8_ovf", overflow, 0);
      chk("add8_count", got.size(), 8);
      for (int i = 0; i < got.size(); i++) chk("add8_result", got[i], 6);

      // Largest three-way product.
      do_reset();
      for (int r = 0; r < 3; r++) send_arg(0, r, 9999);
      send_op(1'b1);
      end_input();
      wait_done(100, "big");
      chk("big_result", got.size() > 0 ? got[0] : 0, 64'd999700029999);
      chk("big_ovf", overflow, 0);

      // Reset while column 1 is combining, then replay.
      do_reset();
      send_example(0);
      seen = 0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         if (result_valid && result_col == 10'd0) seen = 1;
      end
      chk("mid_col0_seen", seen, 1);
      repeat (3) @(posedge clk);
      #1;
      do_reset();
      idle(30);
      chk("mid_total", total_data, 0);
      chk("mid_done", done, 0);
      chk("mid_count", got.size(), 0);
      send_example(1);
      wait_done(200, "replay");
      chk("replay_total", total_data, 4277556);

      // No operators at all.
      do_reset();
      chk("noop_pre_done", done, 0);
      end_input();
      chk("noop_done", done, 1);
      chk("noop_total", total_data, 0);
      idle(10);
      chk("noop_count", got.size(), 0);

      // Random columns with random gaps and ignored out-of-range rows.
      do_reset();
      for (int k = 0; k < 60; k++) begin
         for (int r = 0; r < 3; r++)
            send_arg(k, r, $urandom_range(0, 65535));
         if ($urandom_range(0, 3) == 0)
            send_arg(k, 3, $urandom_range(0, 65535));
         send_op(1'($urandom_range(0, 1)));
         idle($urandom_range(0, 9));
      end
      end_input();
      wait_done(2000, "rnd");
      chk("rnd_count", got.size(), 60);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/problem_scheduler.md
Name: problem_scheduler

Overview:
- Sits downstream of the worksheet input decoder. Stores each decoded argument by (row, column).
- Queues operators as they arrive on the operand row. Evaluates one column problem at a time, using add or multiply across all argument rows.
- Emits a per-column result and keeps a running grand total.
- Serialises the single shared combine datapath across columns, so it is the sequencing controller for the decoded stream.

Parameters:
- ARG_ROWS, 3, number of argument rows per column; the operand row index equals ARG_ROWS.
- ARG_ROW_WIDTH, 2, width of the row index.
- ARG_COL_WIDTH, 10, width of the column index; column storage and operator queue depth are both 2**ARG_COL_WIDTH.
- ARG_DATA_WIDTH, 16, width of an argument value.
- RESULT_WIDTH, 48, width of the per-column result (product/sum accumulator).
- TOTAL_WIDTH, 64, width of the grand total.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- arg_valid  in  1  one-cycle strobe: argument complete.
- arg_row  in  ARG_ROW_WIDTH  argument row index.
- arg_col  in  ARG_COL_WIDTH  argument column index.
- arg_data  in  ARG_DATA_WIDTH  argument value.
- operand_valid  in  1  one-cycle strobe: operator decoded.
- operand_mult_add  in  1  1 = multiply, 0 = add.
- end_of_input  in  1  one-cycle strobe: byte stream finished.
- result_valid  out  1  one-cycle strobe: column result ready.
- result_col  out  ARG_COL_WIDTH  column of result.
- result_data  out  RESULT_WIDTH  column result.
- total_data  out  TOTAL_WIDTH  running sum of all emitted results.
- done  out  1  sticky: end seen, queue empty, FSM idle.
- overflow  out  1  sticky arithmetic overflow flag (see Optional Feature).

Behaviour:
- Clock and reset: single clock clk; reset is synchronous, active-high, on rst.
- Reset values:
  - result_valid=0, result_col=0, result_data=0, total_data=0, done=0, overflow=0.
  - Operator queue empty, operator column counter=0, FSM=IDLE, end_seen=0.
  - Argument storage is not cleared.
- Reset mid-evaluation: the in-flight column is abandoned; no result_valid is emitted after rst.
- Argument store:
  - On arg_valid with arg_row<ARG_ROWS, write arg_data at address {arg_col, arg_row}.
  - Writes with arg_row>=ARG_ROWS are ignored.
  - Synchronous read, 1-cycle latency.
- Operator queue:
  - On operand_valid, push {op_col_cnt, operand_mult_add}, then increment op_col_cnt (wraps at 2**ARG_COL_WIDTH).
  - A push while full is dropped and also sets overflow.
  - Push and pop in the same cycle are both honoured.
- FSM states: IDLE, FETCH, COMBINE, EMIT.
  - IDLE: if queue not empty, pop it; latch col and op; acc=1 for multiply, 0 for add; r=0; go to FETCH.
  - FETCH: issue read {col, r}; go to COMBINE.
  - COMBINE: acc = acc*data (multiply) or acc+data (add), truncated to RESULT_WIDTH. Then r++. If r==ARG_ROWS go to EMIT, else go to FETCH.
  - EMIT: result_valid=1 for one cycle, result_col=col, result_data=acc. total_data += acc in the same cycle (visible next cycle). Go to IDLE.
- Latency: 2*ARG_ROWS+2 cycles per column, from the pop to the cycle after result_valid.
- Hazard: operands are pushed only after all argument rows are written, because the decoder finishes every argument row before the operand row. No read-after-write bypass is required.
- done:
  - end_of_input sets end_seen.
  - done=1 when end_seen && queue empty && FSM==IDLE; held until rst.
  - total_data is final when done=1.
  - end_of_input with an empty queue: done asserts on the next cycle.
- Zero operators received: done asserts with total_data=0.

Optional Feature:
- Macro: PROBLEM_SCHEDULER_OVF_CHECK_EN.
- Defined: overflow also latches 1 when a combine result or a total addition exceeds its width. Detection is via a full-width product/sum compare.
- Undefined: only a queue push-while-full sets overflow. The arithmetic silently truncates, and the extra compare logic is absent.

Decomposition:
- Package problem_scheduler_pkg:
  - sched_state_t enum (IDLE, FETCH, COMBINE, EMIT).
  - op_t (OP_ADD=0, OP_MULT=1).
  - Default width localparams.
  - op_entry_t struct {col, op}.
- One sub-module: op_queue, a synchronous single-clock FIFO of op_entry_t with full/empty, depth 2**ARG_COL_WIDTH, first-word-fall-through read.

Test Plan:
- Worksheet example, 4 columns:
  - Args "123 328 51 64 / 45 64 387 23 / 6 98 215 314", operators "* + * +".
  - Expect results 33210, 490, 4243455, 401 on cols 0..3, in order.
  - Expect total_data=4277556 and done=1 after end_of_input.
- Back-to-back operand_valid every 2 cycles for 8 columns of all-add args (1,2,3) -> 8 results of 6; queue never overflows; total=48; overflow=0.
- Single multiply column, args 9999,9999,9999 -> result 999700029999; overflow=0 with and without the macro.
- RESULT_WIDTH=16, multiply 300*300*1:
  - With the macro defined: overflow=1.
  - Without the macro: overflow=0 and result is truncated to 24464.
- Assert rst during COMBINE of column 1 of the example -> no further result_valid, total_data=0, done=0. Replaying the full stream then yields 4277556.
- end_of_input with no operands -> done=1 next cycle, total_data=0, result_valid never asserted.
